// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ producers, with bursts of up to MAX_BURST words.
// Optional ARB_LOCK_EN adds a per-requester lock input that lifts the burst limit for a locked owner.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
`ifdef ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            lock,
`endif
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_full,
  output logic                          busy,
  output logic [ID_WIDTH-1:0]           owner
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [ID_WIDTH-1:0] owner_nxt, rr_ptr, rr_ptr_nxt, winner, owner_inc, idx;
  logic [CNT_W-1:0]    burst_cnt, burst_cnt_nxt;
  logic                found, owner_req, accept, last_word, locked;

  // First requester at or above rr_ptr, wrapping at NUM_REQ
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = ID_WIDTH'((32'(rr_ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

`ifdef ARB_LOCK_EN
  assign locked = lock[owner];
`else
  assign locked = 1'b0;
`endif

  assign owner_inc = ID_WIDTH'((32'(owner) + 1) % NUM_REQ);
  assign owner_req = req[owner];
  assign last_word = (burst_cnt == CNT_W'(MAX_BURST - 1));
  assign accept    = (state == GRANT) && owner_req && !fifo_full;
  assign busy      = (state == GRANT);

  // Write port is a direct mux of the owner's slice, qualified by the strobe
  assign fifo_wr      = accept;
  assign gnt          = accept ? (NUM_REQ'(1) << owner) : '0;
  assign fifo_wr_data = accept ? req_data[32'(owner)*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          owner_nxt     = winner;
          burst_cnt_nxt = '0;
          state_nxt     = GRANT;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = owner_inc;
        end else if (accept) begin
          // A locked owner saturates the count and keeps the grant
          if (last_word && !locked) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = owner_inc;
          end else if (!last_word) begin
            burst_cnt_nxt = burst_cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
